cpu_axi_master: RTL and testbench



---
 rtl/cpu_axi_master_if.sv | 68 ++++++
 rtl/cpu_axi_master.sv | 159 +++++++++++++++
 tb/tb_cpu_axi_master.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_axi_master_if.sv
// AXI4 bus bundle between a core-side master and the interconnect.
// Only the signals a single-beat, non-burst master needs are carried.
interface cpu_axi_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  // Read address channel
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  // Read data channel
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // Write address channel
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  // Write data channel
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // Write response channel
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_master.sv
// Converts the core's single-word request port into single-beat AXI4
// read or write transactions. One transaction outstanding at a time;
// every AXI output is derived from registered state so the bus never sees
// the core port combinationally.
module cpu_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                stall,
  output logic                done,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  cpu_axi_master_if.master    axi
);

  localparam int STRB_W = DATA_W / 8;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_A    = 3'd1;
  localparam logic [2:0] RD_D    = 3'd2;
  localparam logic [2:0] WR_AW   = 3'd3;
  localparam logic [2:0] WR_RESP = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]        state_q,    state_d;
  logic [ADDR_W-1:0] addr_q,     addr_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [STRB_W-1:0] wstrb_q,    wstrb_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic              aw_done_q,  aw_done_d;
  logic              w_done_q,   w_done_d;
  logic              err_flag_q, err_flag_d;

  logic aw_fire;
  logic w_fire;

  // IDs are not checked: only one transaction is ever in flight.
  logic unused_ids;
  assign unused_ids = ^{axi.rid, axi.bid};

  // Bus outputs decoded from state and capture registers only.
  assign axi.arid    = MASTER_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'd0;
  assign axi.arsize  = 3'b010;
  assign axi.arburst = 2'b01;
  assign axi.arvalid = (state_q == RD_A);
  assign axi.rready  = (state_q == RD_D);

  assign axi.awid    = MASTER_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'd0;
  assign axi.awsize  = 3'b010;
  assign axi.awburst = 2'b01;
  assign axi.awvalid = (state_q == WR_AW) && !aw_done_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wvalid  = (state_q == WR_AW) && !w_done_q;
  assign axi.wlast   = axi.wvalid;
  assign axi.bready  = (state_q == WR_RESP);

  assign aw_fire = axi.awvalid && axi.awready;
  assign w_fire  = axi.wvalid && axi.wready;

  // Core-side status.
  assign done  = (state_q == DONE);
  assign err   = done && err_flag_q;
  assign rdata = rdata_q;
  assign stall = req && !done;

  // Next-state and capture logic for the transaction sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned (no latch).
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    rdata_d    = rdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_flag_d = err_flag_q;

    case (state_q)
      IDLE: begin
        if (req) begin
          // Direction is carried by the state itself; the rest is frozen here.
          addr_d     = addr;
          wdata_d    = wdata;
          wstrb_d    = wstrb;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          err_flag_d = 1'b0;
          state_d    = we ? WR_AW : RD_A;
        end
      end
      RD_A: begin
        if (axi.arready) state_d = RD_D;
      end
      RD_D: begin
        // A beat without RLAST is a protocol violation and is ignored.
        if (axi.rvalid && axi.rlast) begin
          rdata_d    = axi.rdata;
          err_flag_d = (axi.rresp != 2'b00);
          state_d    = DONE;
        end
      end
      WR_AW: begin
        // AW and W complete independently; leave once both have, counting this cycle.
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi.bvalid) begin
          err_flag_d = (axi.bresp != 2'b00);
          state_d    = DONE;
        end
      end
      DONE: begin
        // A waiting request is picked up in IDLE, not here.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      rdata_q    <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      rdata_q    <= rdata_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_flag_q <= err_flag_d;
    end
  end

endmodule

// File: tb/tb_cpu_axi_master.sv
// Bench for cpu_axi_master: a scheduled AXI slave plus a transaction-level
// model that predicts, for each cycle, which channel is busy, when done
// pulses and what rdata holds. Directed cases first, then random traffic.
module tb_cpu_axi_master;

  localparam logic [3:0] MID = 4'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err;

  cpu_axi_master_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  cpu_axi_master #(.MASTER_ID(MID), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .stall (stall),
    .done  (done),
    .rdata (rdata),
    .err   (err),
    .axi   (axi)
  );

  always #5 clk = ~clk;

  // One transaction as the core asks for it plus how the slave will respond.
  // a_wait: extra cycles before ARREADY/AWREADY; w_wait: before WREADY;
  // d_wait: extra cycles before RVALID/BVALID.
  typedef struct {
    bit          active;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic [1:0]  resp;
    int          a_wait;
    int          w_wait;
    int          d_wait;
    int          start;
    int          abort;
  } txn_t;

  // Cycle windows implied by a transaction, counted from its capture cycle.
  typedef struct {
    int ar_hi;
    int rr_hi;
    int aw_hi;
    int w_hi;
    int b_lo;
    int b_hi;
    int dn;
  } sched_t;

  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          checking = 1'b0;
  txn_t        cur;
  logic [31:0] model_rdata = 32'h0;
  int          obs_aw, obs_w, obs_done, obs_err, obs_done_cyc;
  logic [31:0] obs_araddr;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic sched_t sched(input txn_t t);
    sched_t s;
    int     m;
    m       = (t.a_wait > t.w_wait) ? t.a_wait : t.w_wait;
    s.ar_hi = t.start + 1 + t.a_wait;
    s.rr_hi = s.ar_hi + 1 + t.d_wait;
    s.aw_hi = t.start + 1 + t.a_wait;
    s.w_hi  = t.start + 1 + t.w_wait;
    s.b_lo  = t.start + 2 + m;
    s.b_hi  = s.b_lo + t.d_wait;
    s.dn    = t.we ? s.b_hi + 1 : s.rr_hi + 1;
    return s;
  endfunction

  function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] wd,
                              input logic [3:0] st, input logic [31:0] rd, input logic [1:0] rs,
                              input int aw, input int ww, input int dw);
    txn_t t;
    t.active = 1'b0; t.we = w; t.addr = a; t.wdata = wd; t.wstrb = st;
    t.rdata = rd; t.resp = rs; t.a_wait = aw; t.w_wait = ww; t.d_wait = dw;
    t.start = 0; t.abort = 32'h3fff_ffff;
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Compare process: every cycle, DUT outputs against the transaction model.
  always @(negedge clk) begin : cmp
    sched_t s;
    bit     live, e_ar, e_rr, e_aw, e_w, e_b, e_dn, e_err;
    int     c;
    #2;
    if (checking) begin
      c     = cyc;
      s     = sched(cur);
      live  = cur.active && (c <= cur.abort);
      e_ar  = live && !cur.we && c >= cur.start + 1 && c <= s.ar_hi;
      e_rr  = live && !cur.we && c >  s.ar_hi      && c <= s.rr_hi;
      e_aw  = live &&  cur.we && c >= cur.start + 1 && c <= s.aw_hi;
      e_w   = live &&  cur.we && c >= cur.start + 1 && c <= s.w_hi;
      e_b   = live &&  cur.we && c >= s.b_lo        && c <= s.b_hi;
      e_dn  = live && c == s.dn;
      e_err = e_dn && (cur.resp != 2'b00);
      if (e_dn && !cur.we) model_rdata = cur.rdata;

      check("ctl{ar,r,aw,w,b,done,err,stall}",
            {axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready, done, err, stall},
            {e_ar, e_rr, e_aw, e_w, e_b, e_dn, e_err, req && !e_dn});
      check("rdata", rdata, model_rdata);
      if (axi.arvalid)
        check("ar_fields", {axi.arid, axi.araddr, axi.arlen, axi.arsize, axi.arburst},
              {MID, cur.addr, 8'd0, 3'b010, 2'b01});
      if (axi.awvalid)
        check("aw_fields", {axi.awid, axi.awaddr, axi.awlen, axi.awsize, axi.awburst},
              {MID, cur.addr, 8'd0, 3'b010, 2'b01});
      if (axi.wvalid)
        check("w_fields", {axi.wdata, axi.wstrb, axi.wlast}, {cur.wdata, cur.wstrb, 1'b1});

      if (c == cur.start) begin
        obs_aw = 0; obs_w = 0; obs_done = 0; obs_err = 0;
      end
      if (axi.awvalid) obs_aw++;
      if (axi.wvalid)  obs_w++;
      if (axi.arvalid) obs_araddr = axi.araddr;
      if (done) begin obs_done++; obs_done_cyc = c; end
      if (err)  obs_err++;
      if (rst)  model_rdata = 32'h0;
    end
  end

  // Slave responses for cycle c, scheduled from the transaction's wait counts.
  task automatic drive_slave(input txn_t t, input int c);
    sched_t s;
    bit     live;
    s    = sched(t);
    live = t.active && (c <= t.abort);
    axi.arready = live && !t.we && c == s.ar_hi;
    axi.rvalid  = live && !t.we && c == s.rr_hi;
    axi.rdata   = axi.rvalid ? t.rdata : $urandom;
    axi.rresp   = axi.rvalid ? t.resp : 2'($urandom);
    axi.rlast   = axi.rvalid ? 1'b1 : 1'($urandom);
    axi.rid     = 4'($urandom);
    axi.awready = live && t.we && c == s.aw_hi;
    axi.wready  = live && t.we && c == s.w_hi;
    axi.bvalid  = live && t.we && c == s.b_hi;
    axi.bresp   = axi.bvalid ? t.resp : 2'($urandom);
    axi.bid     = 4'($urandom);
  endtask

  // Present one request after `gap` idle cycles and hold it until the model's
  // done cycle; core fields are scrambled after capture. With abort set, rst
  // is pulsed during the second RD_D cycle instead.
  task automatic run_txn(input txn_t t, input int gap, input bit abort_rd);
    sched_t s;
    int     c;
    repeat (gap) begin
      @(negedge clk);
      req = 1'b0;
      drive_slave(cur, cyc);
    end
    @(negedge clk);
    t.active = 1'b1;
    t.start  = cyc;
    t.abort  = abort_rd ? t.start + 3 + t.a_wait : 32'h3fff_ffff;
    cur      = t;
    s        = sched(t);
    req = 1'b1; we = t.we; addr = t.addr; wdata = t.wdata; wstrb = t.wstrb;
    c = cyc;
    while (1) begin
      drive_slave(t, c);
      if (c > t.start) begin
        we = 1'($urandom); addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
      end
      if (abort_rd && c == t.abort) begin
        rst = 1'b1;
        req = 1'b0;
      end
      if (c == s.dn || c == t.abort) break;
      @(negedge clk);
      c = cyc;
    end
    if (abort_rd) begin
      @(negedge clk);
      rst = 1'b0;
      drive_slave(t, cyc);
    end
    #3;
  endtask

  initial begin
    txn_t t;
    int   d1;
    rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    cur = mk(1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 2'b00, 0, 0, 0);
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 1'b0;
    axi.rid = '0; axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
    axi.bresp = '0; axi.bid = '0;

    @(negedge clk);
    checking = 1'b1;
    #3;
    check("reset_state", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready, done, err, rdata},
          {7'b0, 32'h0});
    @(negedge clk);
    rst = 1'b0;

    // Zero-wait read.
    t = mk(1'b0, 32'h0000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00, 0, 0, 0);
    run_txn(t, 1, 1'b0);
    check("rd0_latency", obs_done_cyc - cur.start, 3);
    check("rd0_rdata", rdata, 32'hDEAD_BEEF);
    check("rd0_araddr", obs_araddr, 32'h10);
    check("rd0_done_err", {obs_done, obs_err}, {32'd1, 32'd0});

    // Write, AWREADY three cycles late, WREADY immediate.
    t = mk(1'b1, 32'h20, 32'h1234_5678, 4'b0011, 32'h0, 2'b00, 3, 0, 0);
    run_txn(t, 1, 1'b0);
    check("wr_aw_slow_counts", {obs_aw, obs_w}, {32'd4, 32'd1});
    check("wr_aw_slow_latency", obs_done_cyc - cur.start, 6);
    check("wr_aw_slow_done", obs_done, 1);

    // Write, WREADY three cycles late, AWREADY immediate.
    t = mk(1'b1, 32'h24, 32'hA5A5_0F0F, 4'b1100, 32'h0, 2'b00, 0, 3, 0);
    run_txn(t, 2, 1'b0);
    check("wr_w_slow_counts", {obs_aw, obs_w}, {32'd1, 32'd4});
    check("wr_w_slow_done", obs_done, 1);

    // Read returning SLVERR.
    t = mk(1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFE_0001, 2'b10, 1, 0, 1);
    run_txn(t, 1, 1'b0);
    check("rd_err_pulses", {obs_done, obs_err}, {32'd1, 32'd1});
    check("rd_err_rdata", rdata, 32'hCAFE_0001);

    // Back-to-back read then write, req held throughout.
    t = mk(1'b0, 32'h40, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00, 0, 0, 0);
    run_txn(t, 1, 1'b0);
    d1 = obs_done_cyc;
    t = mk(1'b1, 32'h48, 32'h5555_AAAA, 4'b1111, 32'h0, 2'b00, 0, 0, 0);
    run_txn(t, 0, 1'b0);
    check("b2b_done_spacing", obs_done_cyc - d1, 4);
    check("b2b_done_once", obs_done, 1);

    // Reset while waiting for read data, then a clean read.
    t = mk(1'b0, 32'h50, 32'h0, 4'h0, 32'h1111_2222, 2'b00, 0, 0, 5);
    run_txn(t, 1, 1'b1);
    check("abort_no_done", obs_done, 0);
    check("abort_rdata_cleared", rdata, 32'h0);
    t = mk(1'b0, 32'h44, 32'h0, 4'h0, 32'h7777_8888, 2'b00, 0, 0, 0);
    run_txn(t, 1, 1'b0);
    check("post_abort_latency", obs_done_cyc - cur.start, 3);
    check("post_abort_rdata", rdata, 32'h7777_8888);

    // Random traffic.
    for (int i = 0; i < 80; i++) begin
      t = mk(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom), $urandom,
             ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      run_txn(t, $urandom_range(0, 2), 1'b0);
      check("rand_done_once", obs_done, 1);
    end

    repeat (3) begin
      @(negedge clk);
      req = 1'b0;
      drive_slave(cur, cyc);
    end
    #3;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
